shared_reg_arbiter: RTL and testbench
=====================================

Name: shared_reg_arbiter

Overview:
- Round-robin controller that gives NREQ requesters access to one shared WIDTH-bit register, so the register has exactly one driver.
- Each granted request is either a write or an add.
- The add path has full-width carry detection, a sticky overflow flag and an optional saturating mode.
- Sits between the requesting always-blocks or engines and the shared state register; it is the single owner of that register.

Parameters:
- NREQ, 4: number of requesters (2..8).
- WIDTH, 4: width of the shared register and of the data operands.
- RESET_VAL, 0: value of the shared register after reset.
- SATURATE, 0: 1 = an overflowing add clamps to all-ones; 0 = an overflowing add wraps modulo 2^WIDTH.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NREQ  per-requester request; held high until the matching gnt bit is seen.
- op  input  NREQ  per-requester operation: 0 = WRITE, 1 = ADD.
- data  input  NREQ*WIDTH  per-requester operand; slice i is data[i*WIDTH +: WIDTH].
- ovf_clr  input  1  clears the sticky overflow flag.
- gnt  output  NREQ  one-hot grant, high for exactly one cycle per serviced request.
- value  output  WIDTH  current contents of the shared register.
- ovf  output  1  sticky flag: set when any add carried out of WIDTH bits.
- busy  output  1  high while in EXEC.

Behaviour:
- Reset (rst high at a clock edge):
  - state = IDLE; value = RESET_VAL; ovf = 0; gnt = 0; busy = 0; rr pointer = 0.
  - Reset has priority over everything, including mid-EXEC: the pending operation is discarded and no gnt is issued.
- FSM has two states, IDLE and EXEC.
- IDLE:
  - If req == 0, stay in IDLE.
  - Otherwise, pick the winner: the first set req bit at or after pointer, searching upward and wrapping from NREQ-1 to 0.
  - Latch the winner index, its op and its data; go to EXEC.
- EXEC (exactly one cycle):
  - gnt[winner] = 1 and busy = 1 for this cycle only.
  - At the end of the cycle, apply the op:
    - WRITE: value = latched data.
    - ADD: compute the (WIDTH+1)-bit sum {1'b0,value} + {1'b0,data}.
  - ADD with carry bit (bit WIDTH) = 1:
    - ovf is set.
    - value = all-ones if SATURATE = 1; otherwise value = sum[WIDTH-1:0].
  - ADD with carry = 0: value = sum[WIDTH-1:0].
  - Then pointer = (winner+1) mod NREQ; return to IDLE.
- Latency:
  - req sampled in IDLE at edge t -> gnt high during cycle t+1.
  - value and ovf updated at edge t+2.
  - Peak throughput is one operation per 2 cycles.
- Requester rules:
  - req, op and data are sampled only in IDLE; changes during EXEC are ignored.
  - A req dropped before it is sampled is simply lost; this is legal.
  - A req still high in the IDLE cycle after its gnt counts as a new request. Because the pointer has advanced past it, other pending requesters win first.
- Flag rules:
  - ovf_clr clears ovf at the next edge.
  - If ovf_clr coincides with an overflowing ADD, set wins and ovf = 1.
  - A WRITE never affects ovf.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,2,...,NREQ-1,0. No requester waits more than NREQ services.
- gnt is registered-state driven, is never multi-hot, and is 0 in IDLE.

Decomposition:
- Package shared_reg_pkg holds:
  - state enum {IDLE, EXEC};
  - op constants OP_WRITE = 1'b0 and OP_ADD = 1'b1;
  - a function for the overflow-checked add, shared with other owners of counters.
- Sub-module rr_pick: purely combinational. Inputs: req vector and pointer. Outputs: a winner-found flag and the winner index. It is parameterised by NREQ and is reusable by other arbiters in the design.

Test Plan (all with WIDTH = 4, NREQ = 4):
- Basic write: after reset, req = 0001, op0 = WRITE, data0 = 4'h9 at edge t -> gnt = 0001 during t+1; value = 4'h9 at t+2; ovf = 0.
- Round-robin: req = 1111 held, every requester doing WRITE of its own index -> gnt sequence 0001, 0010, 0100, 1000, 0001 on alternating cycles; value follows 0, 1, 2, 3, 0.
- Overflow, wrapping: value = 4'hC, requester 2 ADD 4'h6, SATURATE = 0 -> value = 4'h2, ovf = 1. A following ADD 4'h1 -> value = 4'h3, ovf stays 1.
- Overflow, saturating: rebuild with SATURATE = 1, value = 4'hC, ADD 4'h6 -> value = 4'hF, ovf = 1. A non-overflowing ADD 4'h0 leaves value = 4'hF.
- Clear vs set: ovf_clr asserted in the same cycle as an overflowing ADD completes -> ovf = 1. ovf_clr alone on the next cycle -> ovf = 0.
- Reset mid-EXEC: assert rst in the EXEC cycle of a WRITE 4'h5 -> value = RESET_VAL, gnt = 0 on the following cycle, state = IDLE, pointer = 0, ovf = 0.

Source files
------------

// File: rtl/shared_reg_pkg.sv
// Shared types and helpers for the shared-register owner and other counter owners.
package shared_reg_pkg;

  localparam int unsigned MAX_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  localparam logic OP_WRITE = 1'b0;
  localparam logic OP_ADD   = 1'b1;

  // Overflow-checked add of the low w bits of a and b; returns {carry, sum}.
  function automatic logic [MAX_W:0] add_chk(input logic [MAX_W-1:0] a,
                                             input logic [MAX_W-1:0] b,
                                             input int unsigned      w,
                                             input logic             sat);
    logic [MAX_W-1:0] mask;
    logic [MAX_W:0]   full;
    logic             carry;
    logic [MAX_W-1:0] sum;
    mask  = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
    full  = {1'b0, a & mask} + {1'b0, b & mask};
    // Operands are masked, so anything above bit w-1 is exactly the carry.
    carry = |(full >> w);
    sum   = (sat && carry) ? mask : (full[MAX_W-1:0] & mask);
    return {carry, sum};
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set req bit at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned NREQ  = 4,
  localparam int unsigned IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  int unsigned pos;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int k = 0; k < NREQ; k++) begin
      pos = (32'(ptr) + 32'(k)) % NREQ;
      if (!found && req[IDX_W'(pos)]) begin
        found = 1'b1;
        idx   = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Single owner of a shared register: round-robin grants of WRITE/ADD requests
// with carry detection, sticky overflow and optional saturation.
module shared_reg_arbiter
  import shared_reg_pkg::*;
#(
  parameter int unsigned      NREQ      = 4,
  parameter int unsigned      WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               SATURATE  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       op,
  input  logic [NREQ*WIDTH-1:0] data,
  input  logic                  ovf_clr,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      value,
  output logic                  ovf,
  output logic                  busy
);

  localparam int unsigned IDX_W = $clog2(NREQ);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic               op_q, op_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [WIDTH-1:0]   value_q, value_d;
  logic               ovf_q, ovf_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic               busy_q, busy_d;

  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic               carry;
  logic [MAX_W-1:0]   sum_wide;
  logic               unused_sum_hi;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign unused_sum_hi = |(sum_wide >> WIDTH);

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    op_d    = op_q;
    data_d  = data_q;
    value_d = value_q;
    ovf_d   = ovf_q;
    gnt_d   = '0;
    busy_d  = 1'b0;
    {carry, sum_wide} = add_chk(MAX_W'(value_q), MAX_W'(data_q), WIDTH, SATURATE);

    if (ovf_clr) ovf_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          win_d   = pick_idx;
          op_d    = op[pick_idx];
          data_d  = data[32'(pick_idx) * WIDTH +: WIDTH];
          gnt_d   = NREQ'(1) << pick_idx;
          busy_d  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (op_q == OP_ADD) begin
          value_d = WIDTH'(sum_wide);
          // A carry overrides a same-cycle clear.
          if (carry) ovf_d = 1'b1;
        end else begin
          value_d = data_q;
        end
        ptr_d   = (32'(win_q) == NREQ - 1) ? '0 : win_q + IDX_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      op_q    <= OP_WRITE;
      data_q  <= '0;
      value_q <= RESET_VAL;
      ovf_q   <= 1'b0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      op_q    <= op_d;
      data_q  <= data_d;
      value_q <= value_d;
      ovf_q   <= ovf_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt   = gnt_q;
  assign value = value_q;
  assign ovf   = ovf_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench: one wrapping and one saturating instance share the same stimulus.
module tb_shared_reg_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       op;
  logic [NREQ*WIDTH-1:0] data;
  logic                  ovf_clr;

  logic [NREQ-1:0]  gnt_w, gnt_s;
  logic [WIDTH-1:0] value_w, value_s;
  logic             ovf_w, ovf_s, busy_w, busy_s;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  shared_reg_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .RESET_VAL(4'h0), .SATURATE(1'b0)) dut_w (
    .clk(clk), .rst(rst), .req(req), .op(op), .data(data), .ovf_clr(ovf_clr),
    .gnt(gnt_w), .value(value_w), .ovf(ovf_w), .busy(busy_w)
  );

  shared_reg_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .RESET_VAL(4'h0), .SATURATE(1'b1)) dut_s (
    .clk(clk), .rst(rst), .req(req), .op(op), .data(data), .ovf_clr(ovf_clr),
    .gnt(gnt_s), .value(value_s), .ovf(ovf_s), .busy(busy_s)
  );

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; req = '0; op = '0; data = '0; ovf_clr = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One request from requester idx; returns the gnt seen during its EXEC cycle.
  task automatic do_op(input int idx, input logic o, input logic [WIDTH-1:0] d,
                       output logic [NREQ-1:0] g_seen);
    @(negedge clk);
    req[idx] = 1'b1;
    op[idx]  = o;
    data[idx*WIDTH +: WIDTH] = d;
    @(posedge clk);
    @(negedge clk);
    g_seen = gnt_w;
    req = '0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (value_w !== 4'h0 || value_s !== 4'h0) begin
      n_fail++; $display("FAIL reset_value: got %h/%h want 0", value_w, value_s);
    end
    n_checks++;
    if ({ovf_w, ovf_s, busy_w, busy_s} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: ovf %b/%b busy %b/%b want 0", ovf_w, ovf_s, busy_w, busy_s);
    end
    n_checks++;
    if (gnt_w !== 4'b0000 || gnt_s !== 4'b0000) begin
      n_fail++; $display("FAIL reset_gnt: got %b/%b want 0000", gnt_w, gnt_s);
    end
  endtask

  task automatic test_basic_write();
    @(negedge clk);
    req = 4'b0001; op[0] = 1'b0; data[3:0] = 4'h9;
    @(posedge clk);
    @(negedge clk);
    req = '0;
    n_checks++;
    if (gnt_w !== 4'b0001 || busy_w !== 1'b1) begin
      n_fail++; $display("FAIL write_gnt: gnt %b busy %b want 0001 1", gnt_w, busy_w);
    end
    n_checks++;
    if (value_w !== 4'h0) begin
      n_fail++; $display("FAIL write_early: value %h want 0", value_w);
    end
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (value_w !== 4'h9 || ovf_w !== 1'b0) begin
      n_fail++; $display("FAIL write_value: value %h ovf %b want 9 0", value_w, ovf_w);
    end
    n_checks++;
    if (gnt_w !== 4'b0000 || busy_w !== 1'b0) begin
      n_fail++; $display("FAIL write_idle: gnt %b busy %b want 0000 0", gnt_w, busy_w);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    @(negedge clk);
    op = 4'b0000; data = 16'h3210; req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      logic [NREQ-1:0]  exp_g;
      logic [WIDTH-1:0] exp_v;
      exp_g = 4'b0001 << (k % 4);
      exp_v = WIDTH'(k % 4);
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (gnt_w !== exp_g) begin
        n_fail++; $display("FAIL rr_gnt[%0d]: got %b want %b", k, gnt_w, exp_g);
      end
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (value_w !== exp_v || gnt_w !== 4'b0000) begin
        n_fail++; $display("FAIL rr_value[%0d]: value %h gnt %b want %h 0000", k, value_w, gnt_w, exp_v);
      end
    end
    req = '0;
  endtask

  task automatic test_overflow();
    logic [NREQ-1:0] g;
    apply_reset();
    do_op(2, 1'b0, 4'hC, g);
    n_checks++;
    if (g !== 4'b0100 || value_w !== 4'hC || value_s !== 4'hC) begin
      n_fail++; $display("FAIL ovf_setup: gnt %b value %h/%h want 0100 C/C", g, value_w, value_s);
    end
    do_op(2, 1'b1, 4'h6, g);
    n_checks++;
    if (value_w !== 4'h2 || ovf_w !== 1'b1) begin
      n_fail++; $display("FAIL ovf_wrap: value %h ovf %b want 2 1", value_w, ovf_w);
    end
    n_checks++;
    if (value_s !== 4'hF || ovf_s !== 1'b1) begin
      n_fail++; $display("FAIL ovf_sat: value %h ovf %b want F 1", value_s, ovf_s);
    end
    do_op(2, 1'b1, 4'h1, g);
    n_checks++;
    if (value_w !== 4'h3 || ovf_w !== 1'b1) begin
      n_fail++; $display("FAIL ovf_sticky: value %h ovf %b want 3 1", value_w, ovf_w);
    end
    do_op(1, 1'b1, 4'h0, g);
    n_checks++;
    if (value_s !== 4'hF || ovf_s !== 1'b1 || value_w !== 4'h3) begin
      n_fail++; $display("FAIL ovf_add0: value %h/%h ovf_s %b want 3/F 1", value_w, value_s, ovf_s);
    end
  endtask

  task automatic test_clear_vs_set();
    // wrap instance holds 3, saturating holds F: adding D overflows both.
    @(negedge clk);
    req[3] = 1'b1; op[3] = 1'b1; data[15:12] = 4'hD;
    @(posedge clk);
    @(negedge clk);
    req = '0; ovf_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ovf_clr = 1'b0;
    n_checks++;
    if (ovf_w !== 1'b1 || ovf_s !== 1'b1 || value_w !== 4'h0 || value_s !== 4'hF) begin
      n_fail++; $display("FAIL clr_vs_set: ovf %b/%b value %h/%h want 1/1 0/F", ovf_w, ovf_s, value_w, value_s);
    end
    ovf_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ovf_clr = 1'b0;
    n_checks++;
    if (ovf_w !== 1'b0 || ovf_s !== 1'b0) begin
      n_fail++; $display("FAIL clr_alone: ovf %b/%b want 0/0", ovf_w, ovf_s);
    end
  endtask

  task automatic test_reset_mid_exec();
    logic [NREQ-1:0] g;
    do_op(0, 1'b0, 4'hF, g);
    do_op(0, 1'b1, 4'h1, g);
    n_checks++;
    if (ovf_w !== 1'b1 || value_w !== 4'h0) begin
      n_fail++; $display("FAIL mid_setup: ovf %b value %h want 1 0", ovf_w, value_w);
    end
    do_op(0, 1'b0, 4'h7, g);
    // Winner 1 would advance the pointer to 2 if reset failed to clear it.
    @(negedge clk);
    req[1] = 1'b1; op[1] = 1'b0; data[7:4] = 4'h5;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (gnt_w !== 4'b0010) begin
      n_fail++; $display("FAIL mid_gnt: got %b want 0010", gnt_w);
    end
    rst = 1'b1; req = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (value_w !== 4'h0 || gnt_w !== 4'b0000 || busy_w !== 1'b0 || ovf_w !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset: value %h gnt %b busy %b ovf %b want 0 0000 0 0", value_w, gnt_w, busy_w, ovf_w);
    end
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (value_w !== 4'h0 || busy_w !== 1'b0) begin
      n_fail++; $display("FAIL mid_discard: value %h busy %b want 0 0", value_w, busy_w);
    end
    req = 4'b1111; op = '0;
    @(posedge clk);
    @(negedge clk);
    req = '0;
    n_checks++;
    if (gnt_w !== 4'b0001) begin
      n_fail++; $display("FAIL mid_ptr: gnt %b want 0001", gnt_w);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; req = '0; op = '0; data = '0; ovf_clr = 1'b0;
    test_reset();
    test_basic_write();
    test_round_robin();
    test_overflow();
    test_clear_vs_set();
    test_reset_mid_exec();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
